serial_adder: RTL and testbench
===============================

// Module: serial_adder
//
// PURPOSE
//   Bit-serial N-bit adder built around one full-adder cell and a carry flip-flop.
//   Accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake.
//   Adds one bit per clock, LSB first. Returns the WIDTH-bit sum and carry-out
//   through a valid/ready handshake.
//   Sits downstream of operand producers and replaces a WIDTH-wide ripple adder
//   where area matters more than throughput.
//
// PARAMETERS
//   WIDTH   8   operand/sum width in bits; legal range 2..64
//
// PORTS
//   Clocking: one clock; reset is asynchronous and active-low.
//   clk        input   1      clock; all state updates on rising edge
//   rst_n      input   1      asynchronous active-low reset
//   in_valid   input   1      a, b, cin valid
//   in_ready   output  1      block can accept an operation
//   a          input   WIDTH  operand A
//   b          input   WIDTH  operand B
//   cin        input   1      carry-in
//   out_valid  output  1      sum/cout valid
//   out_ready  input   1      consumer accepts result
//   sum        output  WIDTH  (a + b + cin) mod 2^WIDTH
//   cout       output  1      bit WIDTH of a + b + cin
//   busy       output  1      high in ADD or DONE
//
// BEHAVIOUR
//   Reset (rst_n low, any state, effective immediately)
//     - state=IDLE; in_ready=1 once rst_n is high; out_valid=0; busy=0.
//     - sum=0; cout=0.
//     - Internal operand shift registers, carry flop and bit counter cleared.
//     - An in-flight operation is discarded.
//   States: IDLE, ADD, DONE.
//   IDLE
//     - in_ready=1.
//     - On in_valid && in_ready: latch a, b into shift regs; carry<=cin; cnt<=0.
//     - Transition -> ADD.
//   ADD (in_ready=0, in_valid ignored)
//     - Each cycle: s = a_sh[0]^b_sh[0]^carry; carry <= majority(a_sh[0], b_sh[0], carry).
//     - Result reg shifts right with s inserted at MSB; a_sh, b_sh shift right.
//     - cnt increments.
//     - On the cycle with cnt==WIDTH-1: -> DONE.
//   DONE
//     - out_valid=1; sum=result reg; cout=carry flop.
//     - sum/cout held stable while out_valid && !out_ready.
//     - On out_ready: -> IDLE; out_valid falls next cycle; sum/cout keep last value.
//   Timing
//     - Latency: accept at edge E -> out_valid high after edge E+WIDTH.
//     - No overlap: new input is accepted only in IDLE.
//     - Minimum period per operation: WIDTH+2 cycles with out_ready tied high.
//   Simultaneous events
//     - in_valid during ADD/DONE is not consumed; the producer must hold it.
//     - out_ready outside DONE has no effect.
//   Arithmetic is unsigned. Signed overflow detection is the consumer's job.
//
// TESTING
//   WIDTH=8 in all directed tests.
//   1 a=0x35 b=0x4A cin=0
//       -> sum=0x7F cout=0; out_valid rises exactly 8 cycles after the accept edge.
//   2 a=0xFF b=0x01 cin=0
//       -> sum=0x00 cout=1 (carry ripples through every bit).
//   3 a=0xFF b=0xFF cin=1
//       -> sum=0xFF cout=1.
//      a=0x00 b=0x00 cin=1
//       -> sum=0x01 cout=0.
//   4 Back-pressure: hold out_ready=0 for 5 cycles in DONE, pulse in_valid meanwhile
//       -> out_valid, sum, cout stable; in_ready=0; no second op accepted.
//       -> After out_ready=1, in_ready=1 in the next cycle.
//   5 Drop rst_n after ADD cycle 4 of a=0xAA b=0x55
//       -> out_valid=0, sum=0, cout=0 immediately; in_ready=1 after rst_n rises.
//       -> A following op a=0x10 b=0x20 cin=0 gives sum=0x30.
//   6 1000 random (a, b, cin) with random in_valid/out_ready stalls
//       -> every result equals {cout,sum} = a+b+cin, in order.
//       -> No lost or duplicated transaction.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, one full-adder cell and a carry flop,
// LSB first, valid/ready handshakes on the operand and result sides.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             s, c_nx, last;

    assign s    = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_nx = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    assign last = cnt == CW'(WIDTH - 1);

    assign in_ready  = rst_n && state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state != IDLE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? ADD : IDLE;
            ADD:     state_nx = last ? DONE : ADD;
            DONE:    state_nx = out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // sum/cout are separate registers so they hold after the result is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == ADD) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            res   <= {s, res[WIDTH-1:1]};
            carry <= c_nx;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= {s, res[WIDTH-1:1]};
                cout <= c_nx;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomized checks of serial_adder (WIDTH=8)
// against an arithmetic reference a+b+cin.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] sum;
    logic       cout;
    logic       busy;

    int checks = 0;
    int failures = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    initial forever #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive one operation and wait for its result; lat counts edges from accept to out_valid
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         output logic [8:0] res, output int lat);
        int w = 0;
        while (!in_ready && w < 100) begin step(); w++; end
        a = ia; b = ib; cin = ic; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin step(); lat++; end
        res = {cout, sum};
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if ({cout, sum} !== 9'h000) begin failures++; $display("FAIL reset_result got=%h exp=000", {cout, sum}); end
        step();
        rst_n = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_directed();
        logic [8:0] r;
        int lat;
        do_op(8'h35, 8'h4A, 1'b0, r, lat);
        checks++; if (r !== 9'h07F) begin failures++; $display("FAIL dir_35_4a got=%h exp=07f", r); end
        checks++; if (lat !== 8) begin failures++; $display("FAIL latency got=%0d exp=8", lat); end
        do_op(8'hFF, 8'h01, 1'b0, r, lat);
        checks++; if (r !== 9'h100) begin failures++; $display("FAIL dir_ff_01 got=%h exp=100", r); end
        do_op(8'hFF, 8'hFF, 1'b1, r, lat);
        checks++; if (r !== 9'h1FF) begin failures++; $display("FAIL dir_ff_ff_c got=%h exp=1ff", r); end
        do_op(8'h00, 8'h00, 1'b1, r, lat);
        checks++; if (r !== 9'h001) begin failures++; $display("FAIL dir_00_00_c got=%h exp=001", r); end
        checks++; if ({cout, sum} !== 9'h001) begin failures++; $display("FAIL hold_after_take got=%h exp=001", {cout, sum}); end
    endtask

    task automatic test_backpressure();
        int w = 0;
        a = 8'h9C; b = 8'h7B; cin = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        while (!out_valid && w < 100) begin step(); w++; end
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", i, out_valid); end
            checks++; if ({cout, sum} !== 9'h118) begin failures++; $display("FAIL bp_result cyc=%0d got=%h exp=118", i, {cout, sum}); end
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, in_ready); end
            a = 8'h01; b = 8'h02; cin = 1'b0; in_valid = i[0];
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_out_valid got=%b exp=0", out_valid); end
        repeat (3) step();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_second_op busy=%b out_valid=%b exp=0,0", busy, out_valid); end
    endtask

    task automatic test_reset_midop();
        logic [8:0] r;
        int lat;
        a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_state out_valid=%b busy=%b exp=0,0", out_valid, busy); end
        checks++; if ({cout, sum} !== 9'h000) begin failures++; $display("FAIL midrst_result got=%h exp=000", {cout, sum}); end
        step();
        step();
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", in_ready); end
        step();
        do_op(8'h10, 8'h20, 1'b0, r, lat);
        checks++; if (r !== 9'h030) begin failures++; $display("FAIL midrst_next_op got=%h exp=030", r); end
    endtask

    task automatic test_random();
        logic [8:0] q[$];
        logic [8:0] e;
        int sent = 0, got = 0, cyc = 0;
        bit acc, ret;
        in_valid = 1'b0; out_ready = 1'b0;
        while (got < 1000 && cyc < 60000) begin
            acc = in_valid && in_ready;
            ret = out_valid && out_ready;
            if (ret) begin
                got++;
                if (q.size() == 0) begin
                    checks++; failures++; $display("FAIL rand_spurious got=%h", {cout, sum});
                end else begin
                    e = q.pop_front();
                    checks++; if ({cout, sum} !== e) begin failures++; $display("FAIL rand_result n=%0d got=%h exp=%h", got, {cout, sum}, e); end
                end
            end
            if (acc) begin
                q.push_back(9'(a) + 9'(b) + 9'(cin));
                sent++;
            end
            step();
            cyc++;
            if (acc || !in_valid) begin
                in_valid = sent < 1000 && $urandom_range(3) != 0;
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            end
            out_ready = 1'($urandom);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (got !== 1000) begin failures++; $display("FAIL rand_count got=%0d exp=1000", got); end
        checks++; if (q.size() !== 0) begin failures++; $display("FAIL rand_leftover got=%0d exp=0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
